// File: rtl/pippo_muldiv_seq_if.sv
// rtl/pippo_muldiv_seq_if.sv - issue-side request/response bundle for the mul/div sequencer
interface pippo_muldiv_seq_if #(
  parameter int width = 64
);
  logic             start;
  logic [2:0]       op;
  logic [width-1:0] opa;
  logic [width-1:0] opb;
  logic             flush;
  logic             busy;
  logic             done;
  logic [width-1:0] result;

  modport master (
    output start, op, opa, opb, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, opa, opb, flush,
    output busy, done, result
  );
endinterface

// File: rtl/pippo_muldiv_seq.sv
// rtl/pippo_muldiv_seq.sv - radix-2 iterative RV64 M-extension multiply/divide sequencer
module pippo_muldiv_seq #(
  parameter int width = 64
) (
  input logic               clk,
  input logic               rst,
  pippo_muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(width);
  localparam logic [width-1:0] SMIN = {1'b1, {(width-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state, state_nx;
  logic [2:0]         op_q;
  logic [width-1:0]   a_q, b_q;
  logic [width-1:0]   opnd;
  logic [2*width-1:0] acc;
  logic [width-1:0]   rem;
  logic [CW-1:0]      cnt;
  logic               neg_q, neg_r, spec_q;
  logic [width-1:0]   spec_res;
  logic [width-1:0]   result_q;

  logic               is_div, signed_a, signed_b, neg_a, neg_b;
  logic               div_zero, div_ovf, special;
  logic [width-1:0]   abs_a, abs_b;
  logic [width:0]     mul_sum, div_shift, div_trial;
  logic [2*width-1:0] prod;
  logic [width-1:0]   quot, rem_fix, fix_sel;

  assign is_div   = op_q[2];
  assign signed_a = (op_q != 3'd3) && (op_q != 3'd5) && (op_q != 3'd7);
  assign signed_b = signed_a && (op_q != 3'd2);
  assign neg_a    = signed_a & a_q[width-1];
  assign neg_b    = signed_b & b_q[width-1];
  assign abs_a    = neg_a ? -a_q : a_q;
  assign abs_b    = neg_b ? -b_q : b_q;
  assign div_zero = is_div && (b_q == '0);
  assign div_ovf  = is_div && !op_q[0] && (a_q == SMIN) && (b_q == '1);
  assign special  = div_zero | div_ovf;

  // acc holds {hi, lo} for multiply; for divide lo carries dividend bits out and quotient bits in
  assign mul_sum   = {1'b0, acc[2*width-1:width]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = {rem, acc[width-1]};
  assign div_trial = div_shift - {1'b0, opnd};

  assign prod    = neg_q ? -acc : acc;
  assign quot    = neg_q ? -acc[width-1:0] : acc[width-1:0];
  assign rem_fix = neg_r ? -rem : rem;

  always_comb begin
    fix_sel = prod[width-1:0];
    if (spec_q) begin
      fix_sel = spec_res;
    end else begin
      case (op_q)
        3'd0:                fix_sel = prod[width-1:0];
        3'd1, 3'd2, 3'd3:    fix_sel = prod[2*width-1:width];
        3'd4, 3'd5:          fix_sel = quot;
        default:             fix_sel = rem_fix;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start && !bus.flush) state_nx = S_PREP;
      // Special divides skip the iteration but still pass through FIX to register the result
      S_PREP: state_nx = bus.flush ? S_IDLE : (special ? S_FIX : S_CALC);
      S_CALC: if (bus.flush) state_nx = S_IDLE;
              else if (cnt == '0) state_nx = S_FIX;
      S_FIX:  state_nx = bus.flush ? S_IDLE : S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      spec_q   <= 1'b0;
      spec_res <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q <= bus.op;
            a_q  <= bus.opa;
            b_q  <= bus.opb;
          end
        end
        S_PREP: begin
          opnd   <= is_div ? abs_b : abs_a;
          acc    <= {{width{1'b0}}, (is_div ? abs_a : abs_b)};
          rem    <= '0;
          cnt    <= CW'(width - 1);
          neg_q  <= neg_a ^ neg_b;
          neg_r  <= neg_a;
          spec_q <= special;
          if (div_zero) spec_res <= op_q[1] ? a_q : '1;
          else          spec_res <= op_q[1] ? '0 : a_q;
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            // Trial subtraction can never exceed width bits, so the shifted-out top bit is safe to drop
            rem <= div_trial[width] ? div_shift[width-1:0] : div_trial[width-1:0];
            acc <= {acc[2*width-1:width], acc[width-2:0], ~div_trial[width]};
          end else begin
            acc <= {mul_sum, acc[width-1:1]};
          end
        end
        S_FIX: begin
          if (!bus.flush) result_q <= fix_sel;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_pippo_muldiv_seq.sv
// tb/tb_pippo_muldiv_seq.sv - self-checking bench for the mul/div sequencer
module tb_pippo_muldiv_seq;
  localparam int W = 64;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] last_res = '0;

  pippo_muldiv_seq_if #(.width(W)) bus ();
  pippo_muldiv_seq #(.width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0] r;
    p = '0;
    r = '0;
    case (op)
      3'd0: begin p = {64'b0, a} * {64'b0, b}; r = p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; r = p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
      3'd4: r = (b == 0) ? ONES : (a == MIN && b == ONES) ? a : 64'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? ONES : a / b;
      3'd6: r = (b == 0) ? a : (a == MIN && b == ONES) ? 64'd0 : 64'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    return op[2] && ((b == 0) || ((op == 3'd4 || op == 3'd6) && a == MIN && b == ONES));
  endfunction

  // inject > 0: stray start after that many edges; inject < 0: stray start in the done cycle
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input string tag, input int inject);
    logic [63:0] exp;
    int exp_lat, edges;
    bit busy_ok, seen;
    exp = model(op, a, b);
    exp_lat = is_special(op, a, b) ? 2 : W + 2;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.opa = {$urandom, $urandom};
    bus.opb = {$urandom, $urandom};
    edges = 0; busy_ok = 1'b1; seen = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      bus.start = 1'b0;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) seen = 1'b1;
      if ((inject > 0 && edges == inject) || (inject < 0 && seen)) begin
        bus.start = 1'b1; bus.op = 3'd0; bus.opa = 64'd1; bus.opb = 64'd1;
      end
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(edges), 64'(exp_lat));
    check({tag, " result"}, bus.result, exp);
    check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
    check({tag, " result_held"}, bus.result, exp);
    last_res = exp;
  endtask

  initial begin
    logic [2:0] rop;
    logic [63:0] ra, rb;
    int sel;
    bit done_seen;

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", {bus.busy, bus.done, bus.result}, 66'd0);
    rst = 1'b0;

    run_op(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul_7x-3", 0);
    run_op(3'd3, ONES, ONES, "mulhu_ones", 0);
    run_op(3'd1, ONES, ONES, "mulh_ones", 0);
    run_op(3'd2, ONES, 64'd2, "mulhsu_-1x2", 0);
    run_op(3'd4, -64'sd7, 64'd2, "div_-7/2", 0);
    run_op(3'd6, -64'sd7, 64'd2, "rem_-7/2", 0);
    run_op(3'd5, 64'd100, 64'd7, "divu_100/7", 10);
    run_op(3'd7, 64'd100, 64'd7, "remu_100/7", -1);
    run_op(3'd5, 64'h1234_5678_9ABC_DEF0, 64'd0, "divu_x/0", 0);
    run_op(3'd6, 64'h1234_5678_9ABC_DEF0, 64'd0, "rem_x/0", -1);
    run_op(3'd4, MIN, ONES, "div_ovf", 0);
    run_op(3'd6, MIN, ONES, "rem_ovf", 1);

    // flush in the middle of the iteration
    run_op(3'd5, 64'd1000, 64'd9, "pre_flush", 0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.opa = 64'd11; bus.opb = 64'd13;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush busy_drop", 64'(bus.busy), 64'd0);
    done_seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    check("flush no_done", 64'(done_seen), 64'd0);
    check("flush result_kept", bus.result, last_res);

    // start and flush together in idle
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.opa = 64'd2; bus.opb = 64'd2;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
    done_seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (bus.busy || bus.done) done_seen = 1'b1;
    end
    check("start_flush dropped", 64'(done_seen), 64'd0);

    // asynchronous reset during the iteration
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.opa = 64'd9; bus.opb = 64'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst outputs", {bus.busy, bus.done, bus.result}, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 64'd3, 64'd5, "mul_3x5", 0);

    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 5);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case (sel)
        0: rb = 64'd0;
        1: begin ra = MIN; rb = ONES; end
        2: begin ra = 64'($signed(32'($urandom)) >>> 8); rb = 64'($urandom_range(1, 300)); end
        default: ;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
